// File: rtl/ps2_pkg.sv
// Shared constants and types for the PS/2 key event receiver.
package ps2_pkg;

  // Prefix scan codes folded into key events
  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [7:0] SC_BRK = 8'hF0;

  // Event word layout: {rpt, ext, brk, code[7:0]}
  localparam int EVT_W = 11;
  localparam int RPT   = 10;
  localparam int EXT   = 9;
  localparam int BRK   = 8;

  // Decode FSM: ST_BRK means an F0 prefix is pending
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BRK  = 1'b1
  } dec_state_e;

endpackage

// File: rtl/ps2_evt_fifo.sv
// Synchronous show-ahead FIFO with occupancy, full and empty flags.
module ps2_evt_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign level_o = cnt_q;

  // A pop frees the slot a same-cycle push needs when full; empty blocks pop
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Head entry shown directly; forced to zero while empty
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // Storage write
  // NOTE: the storage array is deliberately not reset; occupancy and pointers
  // define which entries are meaningful, and resetting RAM costs a mux per bit.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointer and occupancy update; pointers wrap naturally at DEPTH
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/ps2_key_event_rx.sv
// PS/2 keyboard receiver: synchronises the pins, deframes scan codes, folds
// E0/F0 prefixes into key events, tracks the held key for typematic repeats,
// and buffers events in a show-ahead FIFO.
module ps2_key_event_rx
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int CNT_W       = 8,
  parameter int TIMEOUT_CYC = 50000,
  parameter int REPEAT_EN   = 0
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [EVT_W-1:0]              evt_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]              press_cnt,
  output logic                          frame_err,
  output logic                          overflow,
  input  logic                          ovf_clr
);

  localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);

  // Synchronisers
  logic [2:0] ps2c_sync_q;
  logic [1:0] ps2d_sync_q;
  logic       ps2c_fall;

  // Deframer
  logic [3:0]        bit_cnt_q;
  logic [9:0]        shift_q;
  logic [10:0]       frame_w;
  logic              frame_ok;
  logic              timeout;
  logic [IDLE_W-1:0] idle_cnt_q;
  logic              code_vld_q;
  logic [7:0]        code_q;
  logic              frame_err_q;

  // Decode and held tracking
  dec_state_e       state_q, state_d;
  logic             ext_pend_q, ext_pend_d;
  logic [8:0]       held_key_q, held_key_d;
  logic             held_vld_q, held_vld_d;
  logic [CNT_W-1:0] press_cnt_q, press_cnt_d;
  logic [8:0]       key;
  logic             key_match;
  logic             push;
  logic [EVT_W-1:0] evt_d;

  // FIFO side
  logic fifo_full, fifo_empty, pop_req;
  logic overflow_q;

  // Pin synchronisers; the clock chain resets high so reset exit is not a fall
  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the sync chain into one stage.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ps2c_sync_q <= 3'b111;
      ps2d_sync_q <= 2'b11;
    end else begin
      ps2c_sync_q <= {ps2c_sync_q[1:0], ps2_clk};
      ps2d_sync_q <= {ps2d_sync_q[0], ps2_data};
    end
  end

  assign ps2c_fall = ps2c_sync_q[2] & ~ps2c_sync_q[1];

  // Complete frame as seen on the 11th fall: [0] start, [8:1] data, [9] parity, [10] stop
  assign frame_w  = {ps2d_sync_q[1], shift_q};
  assign frame_ok = ~frame_w[0] & frame_w[10] & (^frame_w[9:1]);
  assign timeout  = (bit_cnt_q != '0) && !ps2c_fall &&
                    (idle_cnt_q == IDLE_W'(TIMEOUT_CYC - 1));

  // Bit collection, frame check and idle timeout
  always_ff @(posedge clk) begin
    if (!resetn) begin
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      idle_cnt_q  <= '0;
      code_vld_q  <= 1'b0;
      code_q      <= '0;
      frame_err_q <= 1'b0;
    end else begin
      code_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
      if (ps2c_fall) begin
        idle_cnt_q <= '0;
        if (bit_cnt_q == 4'd10) begin
          bit_cnt_q <= '0;
          if (frame_ok) begin
            code_vld_q <= 1'b1;
            code_q     <= frame_w[8:1];
          end else begin
            frame_err_q <= 1'b1;
          end
        end else begin
          bit_cnt_q <= bit_cnt_q + 4'd1;
          shift_q   <= {ps2d_sync_q[1], shift_q[9:1]};
        end
      end else if (timeout) begin
        bit_cnt_q   <= '0;
        idle_cnt_q  <= '0;
        frame_err_q <= 1'b1;
      end else if (bit_cnt_q == '0) begin
        idle_cnt_q <= '0;
      end else begin
        idle_cnt_q <= idle_cnt_q + IDLE_W'(1);
      end
    end
  end

  assign key       = {ext_pend_q, code_q};
  assign key_match = held_vld_q && (held_key_q == key);
  assign pop_req   = evt_valid & evt_ready;

  // Decode FSM next state, event formation and held-key/press bookkeeping
  // NOTE: every always_comb output gets a default first, so no path leaves a
  // variable unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    ext_pend_d  = ext_pend_q;
    held_key_d  = held_key_q;
    held_vld_d  = held_vld_q;
    press_cnt_d = press_cnt_q;
    push        = 1'b0;
    evt_d       = '0;
    if (frame_err_q) begin
      state_d    = ST_IDLE;
      ext_pend_d = 1'b0;
    end else if (code_vld_q) begin
      if (code_q == SC_EXT) begin
        ext_pend_d = 1'b1;
      end else if (code_q == SC_BRK) begin
        state_d = ST_BRK;
      end else begin
        evt_d[EXT]   = ext_pend_q;
        evt_d[BRK]   = (state_q == ST_BRK);
        evt_d[7:0]   = code_q;
        state_d      = ST_IDLE;
        ext_pend_d   = 1'b0;
        if (state_q == ST_BRK) begin
          push = 1'b1;
          if (key_match) held_vld_d = 1'b0;
        end else if (key_match) begin
          evt_d[RPT] = 1'b1;
          push       = (REPEAT_EN != 0);
        end else begin
          push        = 1'b1;
          press_cnt_d = press_cnt_q + CNT_W'(1);
          held_key_d  = key;
          held_vld_d  = 1'b1;
        end
      end
    end
  end

  // Decode state registers and sticky overflow (set wins over clear)
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= ST_IDLE;
      ext_pend_q  <= 1'b0;
      held_key_q  <= '0;
      held_vld_q  <= 1'b0;
      press_cnt_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ext_pend_q  <= ext_pend_d;
      held_key_q  <= held_key_d;
      held_vld_q  <= held_vld_d;
      press_cnt_q <= press_cnt_d;
      if (push && fifo_full && !pop_req) overflow_q <= 1'b1;
      else if (ovf_clr)                  overflow_q <= 1'b0;
    end
  end

  ps2_evt_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (push),
    .wdata_i (evt_d),
    .pop_i   (pop_req),
    .rdata_o (evt_data),
    .level_o (fifo_level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign evt_valid = ~fifo_empty;
  assign press_cnt = press_cnt_q;
  assign frame_err = frame_err_q;
  assign overflow  = overflow_q;

endmodule
